// File: rtl/divider_pkg.sv
// Shared constants for the divider scheduler and its arbiter.
// State encoding, divide-by-zero quotient and parameter defaults.
package divider_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [31:0] DBZ_Q = 32'hFFFF_FFFF;

   localparam int TAG_W_DEF      = 4;
   localparam int MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter, purely combinational.
// On contention the requester that did not win last time is chosen.
module rr_arb_2 (
   input  logic       en,
   input  logic       vld0,
   input  logic       vld1,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       idx
);

   logic sel;

   assign sel    = (vld0 & vld1) ? ~last : vld1;
   assign idx    = sel;
   assign gnt[0] = en & vld0 & ~sel;
   assign gnt[1] = en & vld1 & sel;

endmodule

// File: rtl/divider_32_sched.sv
// Shares one external divider_32 between two issue ports with a
// round-robin grant, divide-by-zero bypass and hang watchdog.
import divider_pkg::*;

module divider_32_sched #(
   parameter int TAG_W      = TAG_W_DEF,
   parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_vld,
   output logic             req0_rdy,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_vld,
   output logic             req1_rdy,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_vld,
   input  logic             rsp_rdy,
   output logic [31:0]      rsp_q,
   output logic [31:0]      rsp_r,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_dbz,
   output logic             rsp_err,
   output logic [31:0]      div_a,
   output logic [31:0]      div_b,
   output logic             div_start,
   output logic             div_ena,
   input  logic [31:0]      div_q,
   input  logic [31:0]      div_r,
   input  logic             div_dne
);

   localparam logic [7:0] MAX_C = 8'(MAX_CYCLES);

   logic [1:0]       state_q, state_d;
   logic             last_q, last_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             src_q, src_d;
   logic [31:0]      q_q, q_d;
   logic [31:0]      r_q, r_d;
   logic             dbz_q, dbz_d;
   logic             err_q, err_d;

   logic [1:0]  gnt;
   logic        gidx;
   logic        arb_en;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [7:0]  cnt_inc;

   // Gate with reset so no handshake can complete while held in reset.
   assign arb_en = (state_q == S_IDLE) & rst;

   rr_arb_2 u_arb (
      .en   (arb_en),
      .vld0 (req0_vld),
      .vld1 (req1_vld),
      .last (last_q),
      .gnt  (gnt),
      .idx  (gidx)
   );

   assign sel_a   = gidx ? req1_a : req0_a;
   assign sel_b   = gidx ? req1_b : req0_b;
   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      tag_d   = tag_q;
      src_d   = src_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               last_d = gidx;
               src_d  = gidx;
               a_d    = sel_a;
               b_d    = sel_b;
               tag_d  = gidx ? req1_tag : req0_tag;
               dbz_d  = 1'b0;
               err_d  = 1'b0;
               if (sel_b == 32'd0) begin
                  q_d     = DBZ_Q;
                  r_d     = sel_a;
                  dbz_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            cnt_d   = 8'd0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (div_dne) begin
               q_d     = div_q;
               r_d     = div_r;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == MAX_C) begin
                  q_d     = 32'd0;
                  r_d     = 32'd0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rsp_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         tag_q   <= '0;
         src_q   <= 1'b0;
         q_q     <= 32'd0;
         r_q     <= 32'd0;
         dbz_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tag_q   <= tag_d;
         src_q   <= src_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         err_q   <= err_d;
      end
   end

   assign req0_rdy  = gnt[0];
   assign req1_rdy  = gnt[1];
   assign rsp_vld   = (state_q == S_RESP);
   assign rsp_q     = q_q;
   assign rsp_r     = r_q;
   assign rsp_src   = src_q;
   assign rsp_tag   = tag_q;
   assign rsp_dbz   = dbz_q;
   assign rsp_err   = err_q;
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign div_start = (state_q == S_START);
   assign div_ena   = (state_q == S_START) | (state_q == S_BUSY);

endmodule

// File: tb/tb_divider_32_sched.sv
// Directed bench for divider_32_sched with a small divider model
// (3-cycle latency, optional stuck-busy mode for the watchdog).
module tb_divider_32_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_vld = 1'b0, req1_vld = 1'b0;
   logic        req0_rdy, req1_rdy;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]  req0_tag = '0, req1_tag = '0;
   logic        rsp_vld, rsp_rdy = 1'b1;
   logic [31:0] rsp_q, rsp_r;
   logic        rsp_src, rsp_dbz, rsp_err;
   logic [3:0]  rsp_tag;
   logic [31:0] div_a, div_b;
   logic        div_start, div_ena;
   logic [31:0] m_q = '0, m_r = '0;
   logic        m_dne = 1'b0;
   int          m_cnt = 0;
   logic        stuck = 1'b0;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;
   int t_dne;

   divider_32_sched #(.TAG_W(4), .MAX_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req0_vld(req0_vld), .req0_rdy(req0_rdy),
      .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
      .req1_vld(req1_vld), .req1_rdy(req1_rdy),
      .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
      .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_src(rsp_src),
      .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
      .div_a(div_a), .div_b(div_b),
      .div_start(div_start), .div_ena(div_ena),
      .div_q(m_q), .div_r(m_r), .div_dne(m_dne)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (div_start) n_start <= n_start + 1;

   always @(posedge clk) begin
      if (div_start) begin
         m_cnt <= 3;
         m_dne <= 1'b0;
      end else if (div_ena && m_cnt > 0 && !stuck) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_dne <= 1'b1;
            m_q   <= $signed(div_a) / $signed(div_b);
            m_r   <= $signed(div_a) % $signed(div_b);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input bit p, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tg,
                        input bit keep, output int t);
      bit ok;
      ok = 0;
      if (p) begin
         req1_vld = 1; req1_a = a; req1_b = b; req1_tag = tg;
      end else begin
         req0_vld = 1; req0_a = a; req0_b = b; req0_tag = tg;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((p ? req1_rdy : req0_rdy) === 1'b1) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check("grant", {63'd0, ok}, 64'd1);
      check("other_rdy", {63'd0, (p ? req0_rdy : req1_rdy)}, 64'd0);
      t = cyc;
      @(negedge clk);
      if (!keep) begin
         if (p) req1_vld = 0;
         else   req0_vld = 0;
      end
   endtask

   task automatic collect(input int max, output int t_rsp);
      t_rsp = -1;
      t_dne = -1;
      for (int i = 0; i < max; i++) begin
         if (m_dne && div_ena && !div_start && t_dne < 0) t_dne = cyc;
         if (rsp_vld) begin
            t_rsp = cyc;
            break;
         end
         @(negedge clk);
      end
      if (t_rsp < 0) check("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic chk_rsp(input string n, input logic [31:0] q,
                          input logic [31:0] r, input logic src,
                          input logic [3:0] tg, input logic dbz,
                          input logic err);
      check({n, "_q"}, rsp_q, q);
      check({n, "_r"}, rsp_r, r);
      check({n, "_src"}, rsp_src, src);
      check({n, "_tag"}, rsp_tag, tg);
      check({n, "_dbz_err"}, {rsp_dbz, rsp_err}, {dbz, err});
   endtask

   initial begin
      int t, tr, th, s0, bad;
      bit seen;
      // Both requesters valid while still in reset.
      req0_vld = 1; req0_a = 50; req0_b = 5; req0_tag = 4'd1;
      req1_vld = 1; req1_a = -32'sd9; req1_b = 2; req1_tag = 4'd2;
      repeat (3) @(negedge clk);
      check("reset_outs",
            {rsp_vld, req0_rdy, req1_rdy, div_start, div_ena,
             rsp_dbz, rsp_err, rsp_q, div_a}, 64'd0);
      rst = 1;

      issue(0, 50, 5, 4'd1, 1, t);
      collect(30, tr);
      chk_rsp("c1", 32'd10, 32'd0, 1'b0, 4'd1, 1'b0, 1'b0);
      issue(1, -32'sd9, 2, 4'd2, 1, t);
      check("c2_grant_gap", t - tr, 1);
      collect(30, tr);
      chk_rsp("c2", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 4'd2, 1'b0, 1'b0);
      issue(0, 50, 5, 4'd1, 0, t);
      check("c3_grant_gap", t - tr, 1);
      req1_vld = 0;
      collect(30, tr);
      check("c3_q", rsp_q, 32'd10);
      @(negedge clk);

      // Single normal request with exact latencies.
      s0 = n_start;
      issue(0, 100, 7, 4'd3, 0, t);
      check("n_start_at_T1", {63'd0, div_start}, 64'd1);
      collect(30, tr);
      chk_rsp("n", 32'd14, 32'd2, 1'b0, 4'd3, 1'b0, 1'b0);
      check("n_dne_to_vld", tr - t_dne, 1);
      check("n_start_pulses", n_start - s0, 1);
      @(negedge clk);

      // Divide by zero from port 1.
      s0 = n_start;
      issue(1, 1234, 0, 4'd5, 0, t);
      collect(30, tr);
      check("dbz_lat", tr - t, 1);
      chk_rsp("dbz", 32'hFFFF_FFFF, 32'd1234, 1'b1, 4'd5, 1'b1, 1'b0);
      check("dbz_no_start", n_start - s0, 0);
      @(negedge clk);

      // Backpressure with a pending request on port 1.
      rsp_rdy = 0;
      issue(0, 20, 4, 4'd6, 0, t);
      collect(30, tr);
      req1_vld = 1; req1_a = 1000; req1_b = 10; req1_tag = 4'd7;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!rsp_vld || rsp_q !== 32'd5 || rsp_r !== 32'd0 ||
             rsp_tag !== 4'd6 || req1_rdy || req0_rdy) bad++;
         @(negedge clk);
      end
      check("bp_stable", bad, 0);
      rsp_rdy = 1;
      #1;
      check("bp_rdy_in_resp", {63'd0, req1_rdy}, 64'd0);
      th = cyc;
      issue(1, 1000, 10, 4'd7, 0, t);
      check("bp_accept_gap", t - th, 1);
      collect(30, tr);
      chk_rsp("bp", 32'd100, 32'd0, 1'b1, 4'd7, 1'b0, 1'b0);
      @(negedge clk);

      // Watchdog with a hung divider.
      stuck = 1;
      issue(0, 77, 7, 4'd8, 0, t);
      collect(40, tr);
      check("wd_lat", tr - t, 10);
      chk_rsp("wd", 32'd0, 32'd0, 1'b0, 4'd8, 1'b0, 1'b1);
      @(negedge clk);
      stuck = 0;

      // Reset two cycles into BUSY.
      issue(0, 500, 5, 4'd9, 0, t);
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_ena", {63'd0, div_ena}, 64'd1);
      rst = 0;
      #1;
      check("rst_outs",
            {rsp_vld, div_start, div_ena, req0_rdy, req1_rdy,
             rsp_err, rsp_q, div_a}, 64'd0);
      @(negedge clk);
      rst = 1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_vld) seen = 1;
      end
      check("rst_no_rsp", {63'd0, seen}, 64'd0);
      issue(0, 9, 3, 4'd10, 0, t);
      collect(30, tr);
      chk_rsp("post", 32'd3, 32'd0, 1'b0, 4'd10, 1'b0, 1'b0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=done");
      $fatal(1);
   end

endmodule
